// File: rtl/muldiv_seq_if.sv
// Request/result bundle for the sequential multiply/divide unit.
// start/op/a/b are driven by the requester, everything else by the unit.
interface muldiv_seq_if #(
   parameter int WIDTH = 32
);
   // start is a request that counts only on an edge where busy is low and op
   // is 5 (multiply) or 6 (divide); it is dropped otherwise. done pulses for one
   // cycle per accepted request, and hi/lo/div_zero are valid from then on.
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_zero;

   modport master (
      output start, op, a, b,
      input  busy, done, hi, lo, div_zero
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, hi, lo, div_zero
   );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential unsigned multiplier (shift-add) and divider (restoring), one
// iteration per clock; WIDTH iterations per operation.
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst,
   muldiv_seq_if.slave bus,
   output logic [1:0]  dbg_state
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [2:0] OP_MUL = 3'd5;
   localparam logic [2:0] OP_DIV = 3'd6;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FINISH} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d;
   logic [WIDTH:0]     rem_shift;
   logic               rem_ge;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               div_zero_q;
   logic               accept, last_iter, op_valid;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      op_valid  = (bus.op == OP_MUL) || (bus.op == OP_DIV);
      accept    = 1'b0;
      last_iter = (cnt_q == CW'(WIDTH - 1));
      case (state_q)
         IDLE: begin
            if (bus.start && op_valid) begin
               accept = 1'b1;
               if (bus.op == OP_MUL)    state_d = MUL;
               else if (bus.b == '0)    state_d = FINISH;
               else                     state_d = DIV;
            end
         end
         MUL, DIV: if (last_iter) state_d = FINISH;
         FINISH:   state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Multiply: add the multiplicand into the upper half, then shift the whole
   // product right; the carry out of the add becomes the new MSB.
   always_comb begin
      mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
      prod_d  = {mul_sum, prod_q[WIDTH-1:1]};
   end

   // Divide: the partial remainder stays below the divisor, so the shifted value
   // needs exactly one extra bit for the compare/subtract.
   always_comb begin
      rem_shift = {rem_q, quo_q[WIDTH-1]};
      rem_ge    = (rem_shift >= {1'b0, b_q});
      rem_d     = rem_ge ? WIDTH'(rem_shift - {1'b0, b_q}) : rem_shift[WIDTH-1:0];
      quo_d     = {quo_q[WIDTH-2:0], rem_ge};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         prod_q     <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         div_zero_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q        <= bus.a;
                  b_q        <= bus.b;
                  cnt_q      <= '0;
                  prod_q     <= {{WIDTH{1'b0}}, bus.b};
                  rem_q      <= '0;
                  quo_q      <= bus.a;
                  div_zero_q <= 1'b0;
                  if (bus.op == OP_DIV && bus.b == '0) begin
                     hi_q       <= bus.a;
                     lo_q       <= '1;
                     div_zero_q <= 1'b1;
                  end
               end
            end
            MUL: begin
               prod_q <= prod_d;
               cnt_q  <= last_iter ? '0 : cnt_q + 1'b1;
               if (last_iter) begin
                  hi_q <= prod_d[2*WIDTH-1:WIDTH];
                  lo_q <= prod_d[WIDTH-1:0];
               end
            end
            DIV: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= last_iter ? '0 : cnt_q + 1'b1;
               if (last_iter) begin
                  hi_q <= rem_d;
                  lo_q <= quo_d;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = (state_q == FINISH);
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
   assign bus.div_zero = div_zero_q;
   assign dbg_state    = state_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq (WIDTH=32): latency, results, divide-by-zero,
// ignored requests and mid-operation reset.
module tb_muldiv_seq;
   localparam int W = 32;
   localparam logic [2:0] OP_MUL = 3'd5;
   localparam logic [2:0] OP_DIV = 3'd6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] dbg_state;
   int         n_vec = 0;
   int         n_err = 0;
   logic [2*W-1:0] exp_q[$];

   muldiv_seq_if #(.WIDTH(W)) bus ();

   muldiv_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   // Ends on the negedge that follows the accept edge.
   task automatic request(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
      @(negedge clk);
      bus.start = 1'b0; bus.op = 3'd0;
   endtask

   // Edges counted with the accept edge as edge 1; -1 on timeout.
   task automatic wait_done(input int start_edges, output int edges);
      edges = start_edges;
      while (bus.done !== 1'b1 && edges < 100) begin
         @(negedge clk);
         edges++;
      end
      if (bus.done !== 1'b1) edges = -1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin
         n_err++; $display("FAIL reset_flags got=%b want=000", {bus.busy, bus.done, bus.div_zero});
      end
      n_vec++;
      if ({bus.hi, bus.lo} !== 64'd0) begin
         n_err++; $display("FAIL reset_hilo got=%h want=0", {bus.hi, bus.lo});
      end
      n_vec++;
      if (dbg_state !== 2'd0) begin
         n_err++; $display("FAIL reset_state got=%0d want=0", dbg_state);
      end
      rst = 1'b0;
   endtask

   task automatic test_mul_small();
      int n;
      logic [2*W-1:0] e;
      exp_q.push_back({32'd0, 32'd42});
      n_vec++;
      if (bus.busy !== 1'b0) begin
         n_err++; $display("FAIL mul_busy_before got=%b want=0", bus.busy);
      end
      request(OP_MUL, 32'd7, 32'd6);
      n_vec++;
      if (bus.busy !== 1'b1) begin
         n_err++; $display("FAIL mul_busy_after_accept got=%b want=1", bus.busy);
      end
      wait_done(1, n);
      n_vec++;
      if (n !== 33) begin
         n_err++; $display("FAIL mul_latency got=%0d want=33", n);
      end
      e = exp_q.pop_front();
      n_vec++;
      if ({bus.hi, bus.lo} !== e) begin
         n_err++; $display("FAIL mul_7x6 got=%h want=%h", {bus.hi, bus.lo}, e);
      end
      @(negedge clk);
      n_vec++;
      if ({bus.done, bus.busy} !== 2'b00) begin
         n_err++; $display("FAIL mul_done_one_cycle got=%b want=00", {bus.done, bus.busy});
      end
   endtask

   task automatic test_mul_max();
      int n;
      logic [2*W-1:0] e;
      exp_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
      request(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(1, n);
      e = exp_q.pop_front();
      n_vec++;
      if ({bus.hi, bus.lo} !== e) begin
         n_err++; $display("FAIL mul_max got=%h want=%h", {bus.hi, bus.lo}, e);
      end
      n_vec++;
      if (bus.div_zero !== 1'b0) begin
         n_err++; $display("FAIL mul_max_dz got=%b want=0", bus.div_zero);
      end
   endtask

   task automatic test_div();
      int n;
      logic [2*W-1:0] e;
      exp_q.push_back({32'd2, 32'd14});
      exp_q.push_back({32'd3, 32'd0});
      request(OP_DIV, 32'd100, 32'd7);
      wait_done(1, n);
      n_vec++;
      if (n !== 33) begin
         n_err++; $display("FAIL div_latency got=%0d want=33", n);
      end
      e = exp_q.pop_front();
      n_vec++;
      if ({bus.hi, bus.lo} !== e) begin
         n_err++; $display("FAIL div_100_7 got=%h want=%h", {bus.hi, bus.lo}, e);
      end
      request(OP_DIV, 32'd3, 32'd10);
      wait_done(1, n);
      e = exp_q.pop_front();
      n_vec++;
      if ({bus.hi, bus.lo} !== e) begin
         n_err++; $display("FAIL div_3_10 got=%h want=%h", {bus.hi, bus.lo}, e);
      end
   endtask

   task automatic test_div_zero();
      int n;
      request(OP_DIV, 32'd5, 32'd0);
      wait_done(1, n);
      n_vec++;
      if (n !== 1) begin
         n_err++; $display("FAIL dz_latency got=%0d want=1", n);
      end
      n_vec++;
      if ({bus.div_zero, bus.hi, bus.lo} !== {1'b1, 32'd5, 32'hFFFF_FFFF}) begin
         n_err++; $display("FAIL dz_result got=%b/%h/%h want=1/5/ffffffff", bus.div_zero, bus.hi, bus.lo);
      end
      // A following multiply clears the flag at accept but keeps hi/lo until done.
      request(OP_MUL, 32'd3, 32'd4);
      n_vec++;
      if ({bus.div_zero, bus.hi, bus.lo} !== {1'b0, 32'd5, 32'hFFFF_FFFF}) begin
         n_err++; $display("FAIL dz_clear_hold got=%b/%h/%h want=0/5/ffffffff", bus.div_zero, bus.hi, bus.lo);
      end
      wait_done(1, n);
      n_vec++;
      if ({bus.hi, bus.lo} !== {32'd0, 32'd12}) begin
         n_err++; $display("FAIL dz_next_mul got=%h want=%h", {bus.hi, bus.lo}, {32'd0, 32'd12});
      end
   endtask

   task automatic test_ignored();
      int n;
      int busy_seen;
      int done_seen;
      busy_seen = 0;
      done_seen = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd9; bus.b = 32'd9;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) bus.op = 3'd7;
         @(negedge clk);
         busy_seen += int'(bus.busy);
      end
      bus.start = 1'b0;
      n_vec++;
      if (busy_seen !== 0) begin
         n_err++; $display("FAIL bad_op_busy got=%0d want=0", busy_seen);
      end
      n_vec++;
      if ({bus.hi, bus.lo} !== {32'd0, 32'd12}) begin
         n_err++; $display("FAIL bad_op_hold got=%h want=%h", {bus.hi, bus.lo}, {32'd0, 32'd12});
      end
      // Accept 9*9, then disturb start/op/a/b while busy.
      request(OP_MUL, 32'd9, 32'd9);
      bus.start = 1'b1; bus.op = OP_DIV; bus.a = 32'd1; bus.b = 32'd0;
      @(negedge clk);
      bus.a = 32'hDEAD_BEEF; bus.b = 32'h1234_5678; bus.op = OP_MUL;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(3, n);
      n_vec++;
      if (n !== 33) begin
         n_err++; $display("FAIL busy_pulse_latency got=%0d want=33", n);
      end
      n_vec++;
      if ({bus.hi, bus.lo} !== {32'd0, 32'd81}) begin
         n_err++; $display("FAIL busy_pulse_result got=%h want=%h", {bus.hi, bus.lo}, {32'd0, 32'd81});
      end
      // start during FINISH must not be accepted.
      bus.start = 1'b1; bus.op = OP_MUL; bus.a = 32'd2; bus.b = 32'd2;
      @(negedge clk);
      bus.start = 1'b0;
      n_vec++;
      if (bus.busy !== 1'b0) begin
         n_err++; $display("FAIL finish_start_ignored got=%b want=0", bus.busy);
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         done_seen += int'(bus.done);
      end
      n_vec++;
      if (done_seen !== 0) begin
         n_err++; $display("FAIL extra_done got=%0d want=0", done_seen);
      end
      n_vec++;
      if ({bus.hi, bus.lo} !== {32'd0, 32'd81}) begin
         n_err++; $display("FAIL ignored_hold got=%h want=%h", {bus.hi, bus.lo}, {32'd0, 32'd81});
      end
   endtask

   task automatic test_back_to_back();
      int n;
      request(OP_DIV, 32'd1000, 32'd10);
      wait_done(1, n);
      // First IDLE cycle after done accepts the next request.
      request(OP_DIV, 32'd1001, 32'd10);
      n_vec++;
      if (bus.busy !== 1'b1) begin
         n_err++; $display("FAIL b2b_accept got=%b want=1", bus.busy);
      end
      wait_done(1, n);
      n_vec++;
      if ({n, bus.hi, bus.lo} !== {32'd33, 32'd1, 32'd100}) begin
         n_err++; $display("FAIL b2b_result got=%0d/%h/%h want=33/1/64", n, bus.hi, bus.lo);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      request(OP_MUL, 32'h1234, 32'h10);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      bus.start = 1'b1; bus.op = OP_MUL; bus.a = 32'd5; bus.b = 32'd5;
      @(negedge clk);
      n_vec++;
      if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'd0) begin
         n_err++; $display("FAIL rst_mid got=%b%b/%h/%h want=00/0/0", bus.busy, bus.done, bus.hi, bus.lo);
      end
      n_vec++;
      if (dbg_state !== 2'd0) begin
         n_err++; $display("FAIL rst_priority got=%0d want=0", dbg_state);
      end
      rst = 1'b0;
      bus.a = 32'h1234; bus.b = 32'h10;
      @(negedge clk);
      bus.start = 1'b0; bus.op = 3'd0;
      n_vec++;
      if (bus.busy !== 1'b1) begin
         n_err++; $display("FAIL rst_then_accept got=%b want=1", bus.busy);
      end
      wait_done(1, n);
      n_vec++;
      if ({n, bus.hi, bus.lo} !== {32'd33, 32'd0, 32'h0001_2340}) begin
         n_err++; $display("FAIL rst_then_result got=%0d/%h/%h want=33/0/12340", n, bus.hi, bus.lo);
      end
   endtask

   initial begin
      test_reset();
      test_mul_small();
      test_mul_max();
      test_div();
      test_div_zero();
      test_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 RST  input  1  SHALL be the synchronous, active-high reset, sampled on the CLK rising edge.
REQ-004 START  input  1  SHALL be the operation request, sampled on each CLK edge.
REQ-005 OP  input  3  SHALL be the ALU control code: 3'd5 selects multiply, 3'd6 selects divide, and all other codes are ignored.
REQ-006 A  input  WIDTH  SHALL be the multiplicand or dividend.
REQ-007 B  input  WIDTH  SHALL be the multiplier or divisor.
REQ-008 BUSY  output  1  SHALL be high while an accepted operation is in progress.
REQ-009 DONE  output  1  SHALL be a one-cycle completion pulse.
REQ-010 HI  output  WIDTH  SHALL carry the product upper half or the remainder.
REQ-011 LO  output  WIDTH  SHALL carry the product lower half or the quotient.
REQ-012 DIV_ZERO  output  1  SHALL flag that the last divide had B=0.

Function
REQ-013 The block SHALL implement states IDLE, MUL, DIV and FINISH, with IDLE as the reset state.
REQ-014 A request SHALL be accepted only on an edge where state=IDLE, START=1 and OP is 5 or 6; otherwise START SHALL be ignored without any output change.
REQ-015 On acceptance, A and B SHALL be captured into internal registers, and later changes on A, B or OP SHALL have no effect until the next acceptance.
REQ-016 On acceptance, DIV_ZERO SHALL clear, and HI/LO SHALL hold their previous values until FINISH.
REQ-017 Multiply SHALL use an unsigned shift-add algorithm with one iteration per cycle for exactly WIDTH cycles, producing a 2*WIDTH product split into HI (upper half) and LO (lower half).
REQ-018 Divide SHALL use an unsigned restoring algorithm with one quotient bit per cycle for exactly WIDTH cycles, with LO=quotient and HI=remainder.
REQ-019 An iteration counter SHALL run 0 to WIDTH-1, and the transition MUL/DIV->FINISH SHALL occur on the edge where the counter equals WIDTH-1, with no counter wrap-around.
REQ-020 A divide with captured B=0 SHALL go IDLE->FINISH directly, giving HI=A, LO=all ones and DIV_ZERO=1.
REQ-021 For multiply and for nonzero divide, HI, LO and DONE SHALL be valid in the cycle that begins WIDTH+1 edges after the accept edge.
REQ-022 For divide-by-zero, HI, LO and DONE SHALL be valid one edge after the accept edge.
REQ-023 DONE SHALL be high only in FINISH, for exactly one cycle, after which the state SHALL return to IDLE unconditionally.
REQ-024 BUSY SHALL be high in MUL, DIV and FINISH, and low in IDLE.
REQ-025 START asserted in FINISH SHALL be ignored, so the earliest new acceptance is the first IDLE cycle after DONE.
REQ-026 HI, LO and DIV_ZERO SHALL hold their values after FINISH until the next completion or reset.
REQ-027 Internal accumulators SHALL be at least 2*WIDTH bits (multiply) and WIDTH+1 bits (divide) so that no intermediate result overflows.

Reset
REQ-028 With RST=1 on an edge, the state SHALL become IDLE, the counter SHALL become 0, and BUSY, DONE, DIV_ZERO, HI and LO SHALL all become 0.
REQ-029 RST SHALL take priority over START in the same cycle.
REQ-030 RST asserted mid-operation SHALL abort the operation with no DONE pulse.
REQ-031 After RST deasserts, the block SHALL accept a new request on the next edge.

Verification (WIDTH=32)
REQ-032 Multiply A=7, B=6 -> BUSY rises one edge after accept; DONE high in cycle 33 after accept; HI=0, LO=42.
REQ-033 Multiply A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, DIV_ZERO=0.
REQ-034 Divide A=100, B=7 -> DONE in cycle 33; LO=14, HI=2; divide A=3, B=10 -> LO=0, HI=3.
REQ-035 Divide A=5, B=0 -> DONE one cycle after accept; DIV_ZERO=1, HI=5, LO=0xFFFFFFFF; next multiply clears DIV_ZERO at accept.
REQ-036 START held high with OP=0, and START pulsed during BUSY and during FINISH -> no new acceptance; exactly one DONE per accepted request; results unchanged by the ignored pulses.
REQ-037 RST asserted at iteration 10 of a multiply -> next cycle BUSY=0, HI=LO=0, no DONE; a request issued immediately afterwards completes with correct results.
